// File: rtl/lc3_memaccess_pkg.sv
// Shared op/state encodings and decode helpers for the LC3 MemAccess scheduler.
package lc3_memaccess_pkg;

    typedef enum logic [2:0] {
        OpLd  = 3'd0,
        OpLdr = 3'd1,
        OpLdi = 3'd2,
        OpSt  = 3'd3,
        OpStr = 3'd4,
        OpSti = 3'd5
    } mem_op_t;

    localparam logic [1:0] MEM_STATE_IND_RD = 2'b00;
    localparam logic [1:0] MEM_STATE_RD     = 2'b01;
    localparam logic [1:0] MEM_STATE_WR     = 2'b10;
    localparam logic [1:0] MEM_STATE_IDLE   = 2'b11;

    typedef enum logic [1:0] {
        StIndRd = 2'b00,
        StRd    = 2'b01,
        StWr    = 2'b10,
        StIdle  = 2'b11
    } sched_state_t;

    // Unknown bits never match a case item, so X ops decode as illegal.
    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_indirect(input logic [2:0] op);
        return (op == OpLdi) || (op == OpSti);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OpSt) || (op == OpStr) || (op == OpSti);
    endfunction

    function automatic logic [1:0] mem_state_code(input sched_state_t st);
        case (st)
            StIndRd: return MEM_STATE_IND_RD;
            StRd:    return MEM_STATE_RD;
            StWr:    return MEM_STATE_WR;
            default: return MEM_STATE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lc3_memaccess_sched_if.sv
// Data-memory req/ack bus; the scheduler is master, the memory is slave.
interface lc3_memaccess_sched_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              ack;

    modport master (output req, we, addr, din, input dout, ack);
    modport slave  (input req, we, addr, din, output dout, ack);
endinterface

// File: rtl/lc3_mem_watchdog.sv
// Per-access wait counter; flags expiry after TIMEOUT_CYCLES un-acked request cycles.
module lc3_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Idle or acked cycles restart the count, so each access gets a full budget.
    always_comb begin
        cnt_d = '0;
        if (req_i && !ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = req_i && !ack_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/lc3_memaccess_sched.sv
// LC3 MemAccess scheduler: runs one LD/LDR/LDI/ST/STR/STI as one or two dmem transactions.
// Define LC3_MEMACCESS_TIMEOUT_EN to abort requests that wait TIMEOUT_CYCLES without ack.
module lc3_memaccess_sched
    import lc3_memaccess_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [ADDR_W-1:0]     ea_i,
    input  logic [DATA_W-1:0]     st_data_i,
    lc3_memaccess_sched_if.master dmem_io,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_W-1:0]     memout_o,
    output logic [1:0]            mem_state_o
);
    sched_state_t      state_q, state_d;
    mem_op_t           op_q, op_d;
    logic              req_q, req_d, we_q, we_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, memout_q, memout_d;
    logic [1:0]        mem_state_q;
    logic              ack;
    logic              expired;

    assign ack = dmem_io.ack;

`ifdef LC3_MEMACCESS_TIMEOUT_EN
    lc3_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_q),
        .ack_i    (ack),
        .expired_o(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        req_d    = req_q;
        we_d     = we_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        din_d    = din_q;
        memout_d = memout_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && is_legal_op(op_i)) begin
                    op_d   = mem_op_t'(op_i);
                    addr_d = ea_i;
                    din_d  = st_data_i;
                    req_d  = 1'b1;
                    busy_d = 1'b1;
                    if (is_indirect(op_i)) begin
                        state_d = StIndRd;
                        we_d    = 1'b0;
                    end else if (is_store(op_i)) begin
                        state_d = StWr;
                        we_d    = 1'b1;
                    end else begin
                        state_d = StRd;
                        we_d    = 1'b0;
                    end
                end
            end
            StIndRd: begin
                // Pointer fetched: req stays high, only addr/we change for the second access.
                if (ack) begin
                    addr_d = ADDR_W'(dmem_io.dout);
                    if (op_q == OpSti) begin
                        state_d = StWr;
                        we_d    = 1'b1;
                    end else begin
                        state_d = StRd;
                        we_d    = 1'b0;
                    end
                end
            end
            StRd, StWr: begin
                if (ack) begin
                    if (state_q == StRd) begin
                        memout_d = dmem_io.dout;
                    end
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
        if (expired && (state_q != StIdle)) begin
            state_d = StIdle;
            req_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            op_q        <= OpLd;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            memout_q    <= '0;
            mem_state_q <= MEM_STATE_IDLE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_q       <= req_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            memout_q    <= memout_d;
            mem_state_q <= mem_state_code(state_d);
        end
    end

    assign dmem_io.req  = req_q;
    assign dmem_io.we   = we_q;
    assign dmem_io.addr = addr_q;
    assign dmem_io.din  = din_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign memout_o     = memout_q;
    assign mem_state_o  = mem_state_q;
endmodule

// File: tb/tb_lc3_memaccess_sched.sv
// Bench for lc3_memaccess_sched: vector table plus corner-case sequences, scoreboarded bus/done.
module tb_lc3_memaccess_sched;
    localparam int unsigned TO_CYC = 8;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
    } bus_exp_t;

    typedef struct {
        logic [15:0] memout;
        logic        err;
    } done_exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] ea;
        logic [15:0] data;
        logic [15:0] ptr;
        logic [15:0] val;
        int unsigned wait_c;
        logic [15:0] exp_memout;
        int unsigned exp_lat;
        logic [1:0]  exp_st1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] ea, st_data;
    logic        busy, done, err;
    logic [15:0] memout;
    logic [1:0]  mem_state;

    always #5 clk = ~clk;

    lc3_memaccess_sched_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lc3_memaccess_sched #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .ea_i       (ea),
        .st_data_i  (st_data),
        .dmem_io    (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .memout_o   (memout),
        .mem_state_o(mem_state)
    );

    // Memory model: ack comes after mem_wait un-acked request cycles of each access.
    logic [15:0] mem [0:65535];
    int unsigned mem_wait;
    bit          mem_dead;
    bit          force_ack;
    int unsigned wcnt = 0;

    assign bus.ack  = (bus.req && !mem_dead && (wcnt >= mem_wait)) || force_ack;
    assign bus.dout = bus.ack ? mem[bus.addr] : 16'h0000;

    always @(posedge clk) begin
        if (!bus.req || bus.ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (bus.req && bus.ack && bus.we) mem[bus.addr] <= bus.din;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    vec_t        vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: wait for the falling edge, then score any bus transaction or done pulse.
    task automatic tick();
        bus_exp_t  be;
        done_exp_t de;
        @(negedge clk);
        cyc++;
        if (bus.req && bus.ack) begin
            if (bus_q.size() == 0) begin
                check("unexpected_txn", 32'(bus.addr), 32'hFFFF_FFFF);
            end else begin
                be = bus_q.pop_front();
                check("txn_we", 32'(bus.we), 32'(be.we));
                check("txn_addr", 32'(bus.addr), 32'(be.addr));
                if (be.we) check("txn_din", 32'(bus.din), 32'(be.din));
            end
        end
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                de = done_q.pop_front();
                check("done_memout", 32'(memout), 32'(de.memout));
                check("done_err", 32'(err), 32'(de.err));
                check("done_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d,
                         output int unsigned t0);
        start   = 1'b1;
        op      = o;
        ea      = a;
        st_data = d;
        t0      = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned t0, input int unsigned exp_lat);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                check("req_held", 32'(bus.req), 32'd1);
                check("busy_held", 32'(busy), 32'd1);
                tick();
            end
        end
        check("done_arrived", 32'(got), 32'd1);
        if (got) begin
            check("latency", cyc - t0, exp_lat);
            check("done_req_low", 32'(bus.req), 32'd0);
            check("done_mem_state", 32'(mem_state), 32'h3);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned t0;
        logic [15:0] tgt;
        bit          ind, ld;
        ind      = (v.op == 3'd2) || (v.op == 3'd5);
        ld       = (v.op <= 3'd2);
        tgt      = ind ? v.ptr : v.ea;
        mem_wait = v.wait_c;
        if (ind) mem[v.ea] <= v.ptr;
        if (ld) mem[tgt] <= v.val;
        if (ind) bus_q.push_back('{we: 1'b0, addr: v.ea, din: 16'h0000});
        bus_q.push_back('{we: !ld, addr: tgt, din: v.data});
        done_q.push_back('{memout: v.exp_memout, err: 1'b0});
        issue(v.op, v.ea, v.data, t0);
        check("c1_mem_state", 32'(mem_state), 32'(v.exp_st1));
        check("c1_we", 32'(bus.we), 32'(ind ? 1'b0 : !ld));
        check("c1_addr", 32'(bus.addr), 32'(v.ea));
        wait_done(t0, v.exp_lat);
        if (!ld) check("mem_written", 32'(mem[tgt]), 32'(v.data));
    endtask

    initial begin
        int unsigned t0;
        int unsigned dc;
        // op: LD=0 LDR=1 LDI=2 ST=3 STR=4 STI=5; latency = 2+w direct, 3+2w indirect
        vecs[0] = '{3'd0, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 2, 2'b01};
        vecs[1] = '{3'd5, 16'h3010, 16'h1234, 16'h4000, 16'h0000, 0, 16'hBEEF, 3, 2'b00};
        vecs[2] = '{3'd1, 16'h1234, 16'h0000, 16'h0000, 16'h5A5A, 1, 16'h5A5A, 3, 2'b01};
        vecs[3] = '{3'd3, 16'hFFFF, 16'h0F0F, 16'h0000, 16'h0000, 0, 16'h5A5A, 2, 2'b10};
        vecs[4] = '{3'd2, 16'h0000, 16'h0000, 16'hFFFE, 16'h8001, 3, 16'h8001, 9, 2'b00};
        vecs[5] = '{3'd4, 16'h2000, 16'hCAFE, 16'h0000, 16'h0000, 2, 16'h8001, 4, 2'b10};

        rst       = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        ea        = 16'h0;
        st_data   = 16'h0;
        mem_wait  = 0;
        mem_dead  = 1'b0;
        force_ack = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_memout", 32'(memout), 32'd0);
        check("rst_mem_state", 32'(mem_state), 32'h3);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Starts while busy are dropped: only one read, one done.
        mem_wait = 3;
        mem[16'h0100] <= 16'h7777;
        bus_q.push_back('{we: 1'b0, addr: 16'h0100, din: 16'h0000});
        done_q.push_back('{memout: 16'h7777, err: 1'b0});
        issue(3'd0, 16'h0100, 16'h0000, t0);
        start   = 1'b1;
        op      = 3'd3;
        ea      = 16'h0200;
        st_data = 16'hDEAD;
        tick();
        tick();
        start = 1'b0;
        wait_done(t0, 5);

        // Illegal op and a stray ack in idle change nothing.
        dc    = done_cnt;
        start = 1'b1;
        op    = 3'b111;
        ea    = 16'h0300;
        tick();
        start     = 1'b0;
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        check("illegal_busy", 32'(busy), 32'd0);
        check("illegal_req", 32'(bus.req), 32'd0);
        check("illegal_mem_state", 32'(mem_state), 32'h3);
        check("illegal_no_done", done_cnt, dc);
        check("stray_ack_memout", 32'(memout), 32'h7777);

        // STI state walk, then LD issued in the done cycle reads the stored word back.
        mem_wait = 0;
        mem[16'h3020] <= 16'h4100;
        bus_q.push_back('{we: 1'b0, addr: 16'h3020, din: 16'h0000});
        bus_q.push_back('{we: 1'b1, addr: 16'h4100, din: 16'h9999});
        done_q.push_back('{memout: 16'h7777, err: 1'b0});
        issue(3'd5, 16'h3020, 16'h9999, t0);
        check("sti_ms_c1", 32'(mem_state), 32'h0);
        tick();
        check("sti_ms_c2", 32'(mem_state), 32'h2);
        check("sti_addr_c2", 32'(bus.addr), 32'h4100);
        tick();
        check("sti_done_c3", 32'(done), 32'd1);
        check("sti_ms_c3", 32'(mem_state), 32'h3);
        bus_q.push_back('{we: 1'b0, addr: 16'h4100, din: 16'h0000});
        done_q.push_back('{memout: 16'h9999, err: 1'b0});
        issue(3'd0, 16'h4100, 16'h0000, t0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_req", 32'(bus.req), 32'd1);
        check("b2b_ms", 32'(mem_state), 32'h1);
        wait_done(t0, 2);

        // Asynchronous reset in the middle of an indirect read.
        mem_wait = 5;
        mem[16'h5000] <= 16'h5100;
        issue(3'd2, 16'h5000, 16'h0000, t0);
        tick();
        check("pre_rst_ms", 32'(mem_state), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ms", 32'(mem_state), 32'h3);
        check("mid_rst_memout", 32'(memout), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec('{3'd0, 16'h5100, 16'h0000, 16'h0000, 16'h1357, 0, 16'h1357, 2, 2'b01});

`ifdef LC3_MEMACCESS_TIMEOUT_EN
        // No ack ever: req held TO_CYC cycles, then done and err together, memout held.
        mem_dead = 1'b1;
        done_q.push_back('{memout: 16'h1357, err: 1'b1});
        issue(3'd0, 16'h6000, 16'h0000, t0);
        wait_done(t0, TO_CYC + 1);
        check("timeout_err", 32'(err), 32'd1);
        mem_dead = 1'b0;
        tick();
        check("timeout_err_pulse", 32'(err), 32'd0);
`endif

        tick();
        tick();
        check("bus_q_drained", bus_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end
endmodule
